// File: rtl/des_pkg.sv
// rtl/des_pkg.sv - shared widths and state encodings for the DES CBC feeder
package des_pkg;
    localparam int DES_BLK_W  = 64;
    localparam int DES_WORD_W = 32;

    localparam logic [2:0] S_HI    = 3'd0;
    localparam logic [2:0] S_LO    = 3'd1;
    localparam logic [2:0] S_START = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_OUT   = 3'd4;
endpackage

// File: rtl/des_word_pack.sv
// rtl/des_word_pack.sv - packs two 32-bit words (high first) into one 64-bit block
module des_word_pack
    import des_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DES_WORD_W-1:0] s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic                  blk_done,
    output logic                  hi_fire,
    output logic [DES_BLK_W-1:0]  blk,
    output logic                  blk_valid
);
    logic                  phase_q, phase_d;
    logic                  hold_q, hold_d;
    logic [DES_WORD_W-1:0] hi_q, hi_d;
    logic                  s_ready_q;
    logic                  fire;

    assign fire      = s_valid & s_ready_q;
    assign hi_fire   = fire & ~phase_q;
    assign blk_valid = fire & phase_q;
    assign blk       = {hi_q, s_data};
    assign s_ready   = s_ready_q;

    // Input stays closed from the low word until the controller hands the block back.
    always_comb begin
        phase_d = phase_q;
        hold_d  = hold_q;
        hi_d    = hi_q;
        if (hi_fire) begin
            hi_d    = s_data;
            phase_d = 1'b1;
        end
        if (blk_valid) begin
            phase_d = 1'b0;
            hold_d  = 1'b1;
        end
        if (blk_done) begin
            hold_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase_q   <= 1'b0;
            hold_q    <= 1'b0;
            hi_q      <= '0;
            s_ready_q <= 1'b0;
        end else begin
            phase_q   <= phase_d;
            hold_q    <= hold_d;
            hi_q      <= hi_d;
            s_ready_q <= ~hold_d;
        end
    end
endmodule

// File: rtl/des_cbc_feeder.sv
// rtl/des_cbc_feeder.sv - ECB/CBC chaining front end that feeds one block at a time to DES_top
module des_cbc_feeder
    import des_pkg::*;
#(
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cfg_dec,
    input  logic                  cfg_cbc,
    input  logic                  iv_load,
    input  logic [DES_BLK_W-1:0]  iv,
    input  logic [DES_WORD_W-1:0] s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic [DES_BLK_W-1:0]  m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DES_BLK_W-1:0]  core_din,
    output logic                  core_start,
    output logic                  core_mode,
    input  logic [DES_BLK_W-1:0]  core_dout,
    input  logic                  core_valid,
    output logic                  busy,
    output logic                  err
);
    localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);

    logic [2:0]           state_q, state_d;
    logic                 dec_q, dec_d, cbc_q, cbc_d;
    logic [DES_BLK_W-1:0] chain_q, chain_d, blk_q, blk_d;
    logic [DES_BLK_W-1:0] din_q, din_d, mdata_q, mdata_d;
    logic [TMR_W-1:0]     timer_q, timer_d;
    logic                 err_q, err_d;
    logic                 hi_fire, blk_valid, timeout, blk_done;
    logic [DES_BLK_W-1:0] pack_blk;

    des_word_pack u_pack (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .blk_done  (blk_done),
        .hi_fire   (hi_fire),
        .blk       (pack_blk),
        .blk_valid (blk_valid)
    );

    // Expiry is timed so err is visible exactly TIMEOUT_CYC cycles after the start pulse.
    assign timeout  = (state_q == S_WAIT) && !core_valid && (timer_q == TMR_W'(TIMEOUT_CYC - 2));
    assign blk_done = ((state_q == S_OUT) && m_ready) || timeout;

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= S_HI;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_HI:    if (hi_fire) state_d = S_LO;
            S_LO:    if (blk_valid) state_d = S_START;
            S_START: state_d = S_WAIT;
            S_WAIT:  if (core_valid) state_d = S_OUT;
                     else if (timeout) state_d = S_HI;
            S_OUT:   if (m_ready) state_d = S_HI;
            default: state_d = S_HI;
        endcase
    end

    always_comb begin
        core_start = (state_q == S_START);
        m_valid    = (state_q == S_OUT);
        busy       = (state_q != S_HI);
    end

    always_comb begin
        dec_d   = dec_q;
        cbc_d   = cbc_q;
        chain_d = chain_q;
        blk_d   = blk_q;
        din_d   = din_q;
        mdata_d = mdata_q;
        timer_d = timer_q;
        err_d   = err_q;
        case (state_q)
            S_HI: begin
                if (iv_load) begin
                    chain_d = iv;
                    err_d   = 1'b0;
                end
                if (hi_fire) begin
                    dec_d = cfg_dec;
                    cbc_d = cfg_cbc;
                end
            end
            S_LO: begin
                if (blk_valid) begin
                    blk_d = pack_blk;
                    din_d = (cbc_q && !dec_q) ? (pack_blk ^ chain_q) : pack_blk;
                end
            end
            S_START: timer_d = '0;
            S_WAIT: begin
                if (core_valid) begin
                    if (!dec_q) begin
                        mdata_d = core_dout;
                        if (cbc_q) chain_d = core_dout;
                    end else begin
                        mdata_d = cbc_q ? (core_dout ^ chain_q) : core_dout;
                        if (cbc_q) chain_d = blk_q;
                    end
                end else if (timeout) begin
                    err_d = 1'b1;
                end
                if (timer_q != {TMR_W{1'b1}}) timer_d = timer_q + 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dec_q   <= 1'b0;
            cbc_q   <= 1'b0;
            chain_q <= '0;
            blk_q   <= '0;
            din_q   <= '0;
            mdata_q <= '0;
            timer_q <= '0;
            err_q   <= 1'b0;
        end else begin
            dec_q   <= dec_d;
            cbc_q   <= cbc_d;
            chain_q <= chain_d;
            blk_q   <= blk_d;
            din_q   <= din_d;
            mdata_q <= mdata_d;
            timer_q <= timer_d;
            err_q   <= err_d;
        end
    end

    assign core_din  = din_q;
    assign core_mode = dec_q;
    assign m_data    = mdata_q;
    assign err       = err_q;
endmodule

// File: tb/tb_des_cbc_feeder.sv
// tb/tb_des_cbc_feeder.sv - table-driven bench for des_cbc_feeder with a DES_top stand-in
module tb_des_cbc_feeder;
    localparam int          TIMEOUT = 16;
    localparam logic [63:0] PT      = 64'h0123456789abcdef;
    localparam logic [63:0] CT      = 64'h85e813540f0ab405;

    logic        clk = 1'b0;
    logic        rst_n, cfg_dec, cfg_cbc, iv_load, s_valid, m_ready;
    logic [63:0] iv;
    logic [31:0] s_data;
    logic        s_ready, m_valid, core_start, core_mode, busy, err;
    logic [63:0] m_data, core_din;
    logic [63:0] core_dout;
    logic        core_valid;

    always #5 clk = ~clk;

    des_cbc_feeder #(.TIMEOUT_CYC(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_dec(cfg_dec), .cfg_cbc(cfg_cbc),
        .iv_load(iv_load), .iv(iv), .s_data(s_data), .s_valid(s_valid),
        .s_ready(s_ready), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .core_din(core_din), .core_start(core_start), .core_mode(core_mode),
        .core_dout(core_dout), .core_valid(core_valid), .busy(busy), .err(err)
    );

    // Stand-in for DES_top (key 133457799bbcdff1): knows the textbook pair, complements anything else.
    logic        core_dead = 1'b0;
    logic        core_act;
    logic [3:0]  core_cnt;
    logic [63:0] core_cin, seen_din;
    logic        core_cm, seen_mode;
    int          n_starts = 0;
    logic        din_bad = 1'b0;

    function automatic logic [63:0] stub_des(input logic [63:0] x, input logic mode);
        if (!mode && x == PT) return CT;
        if (mode && x == CT) return PT;
        return ~x;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            core_valid <= 1'b0;
            core_dout  <= '0;
            core_act   <= 1'b0;
            core_cnt   <= '0;
            core_cin   <= '0;
            core_cm    <= 1'b0;
        end else begin
            core_valid <= 1'b0;
            if (core_start) begin
                n_starts  <= n_starts + 1;
                seen_din  <= core_din;
                seen_mode <= core_mode;
                if (!core_dead) begin
                    core_act <= 1'b1;
                    core_cnt <= 4'd4;
                    core_cin <= core_din;
                    core_cm  <= core_mode;
                end
            end else if (core_act) begin
                if (core_din != core_cin) din_bad <= 1'b1;
                if (core_cnt == 4'd1) begin
                    core_valid <= 1'b1;
                    core_dout  <= stub_des(core_cin, core_cm);
                    core_act   <= 1'b0;
                end
                core_cnt <= core_cnt - 4'd1;
            end
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_word(input logic [31:0] w, input logic dec, input logic cbc,
                             input logic ld, input logic [63:0] ivv);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (s_ready) begin
                s_data = w; s_valid = 1'b1; cfg_dec = dec; cfg_cbc = cbc;
                iv_load = ld; iv = ivv;
                @(posedge clk);
                #1;
                s_valid = 1'b0; iv_load = 1'b0;
                return;
            end
        end
        check("push_timeout", 64'd1, 64'd0);
    endtask

    task automatic wait_mvalid(input string name);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (m_valid) return;
        end
        check({name, "_mvalid_timeout"}, 64'd1, 64'd0);
    endtask

    task automatic wait_start(input string name);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (core_start) return;
        end
        check({name, "_start_timeout"}, 64'd1, 64'd0);
    endtask

    task automatic accept();
        @(negedge clk);
        m_ready = 1'b1;
        @(posedge clk);
        #1;
        m_ready = 1'b0;
    endtask

    typedef struct {
        string       name;
        logic        dec;
        logic        cbc;
        logic        ld;
        logic [63:0] ivv;
        logic [31:0] w_hi;
        logic [31:0] w_lo;
        logic [63:0] exp_din;
        logic [63:0] exp_m;
    } vec_t;

    task automatic run_vec(input vec_t v);
        int base;
        base = n_starts;
        push_word(v.w_hi, v.dec, v.cbc, v.ld, v.ivv);
        // Flipped cfg on the low word must be ignored.
        push_word(v.w_lo, ~v.dec, ~v.cbc, 1'b0, 64'hdead_beef_dead_beef);
        @(negedge clk);
        check({v.name, "_start_lat"}, 64'(core_start), 64'd1);
        wait_mvalid(v.name);
        check({v.name, "_din"},    seen_din, v.exp_din);
        check({v.name, "_mode"},   64'(seen_mode), 64'(v.dec));
        check({v.name, "_mdata"},  m_data, v.exp_m);
        check({v.name, "_starts"}, 64'(n_starts - base), 64'd1);
        accept();
        @(negedge clk);
        check({v.name, "_drain"}, {62'd0, m_valid, s_ready}, 64'b01);
    endtask

    vec_t vecs[8];

    initial begin
        vecs[0] = '{"ecb_enc",      1'b0, 1'b0, 1'b0, 64'd0, 32'h01234567, 32'h89abcdef, PT, CT};
        vecs[1] = '{"cbc_enc1",     1'b0, 1'b1, 1'b1, 64'd0, 32'h01234567, 32'h89abcdef, PT, CT};
        vecs[2] = '{"cbc_enc2",     1'b0, 1'b1, 1'b0, 64'd0, 32'h01234567, 32'h89abcdef,
                    64'h84cb563386a179ea, 64'h7b34a9cc795e8615};
        vecs[3] = '{"ecb_dec",      1'b1, 1'b0, 1'b0, 64'd0, 32'h85e81354, 32'h0f0ab405, CT, PT};
        vecs[4] = '{"cbc_dec1",     1'b1, 1'b1, 1'b1, 64'd0, 32'h85e81354, 32'h0f0ab405, CT, PT};
        vecs[5] = '{"cbc_dec2",     1'b1, 1'b1, 1'b0, 64'd0, 32'h7b34a9cc, 32'h795e8615,
                    64'h7b34a9cc795e8615, PT};
        vecs[6] = '{"cbc_enc_iv1",  1'b0, 1'b1, 1'b1, 64'd1, 32'h01234567, 32'h89abcdef,
                    64'h0123456789abcdee, 64'hfedcba9876543211};
        vecs[7] = '{"ecb_enc_zero", 1'b0, 1'b0, 1'b0, 64'd0, 32'h00000000, 32'h00000000,
                    64'd0, 64'hffffffffffffffff};

        rst_n = 1'b0; cfg_dec = 1'b0; cfg_cbc = 1'b0; iv_load = 1'b0; iv = '0;
        s_data = '0; s_valid = 1'b0; m_ready = 1'b0;

        @(negedge clk);
        check("rst_s_ready", 64'(s_ready), 64'd0);
        check("rst_outs", {58'd0, m_valid, core_start, core_mode, busy, err, 1'b0}, 64'd0);
        check("rst_m_data", m_data, 64'd0);
        check("rst_core_din", core_din, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_s_ready", 64'(s_ready), 64'd1);

        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        // Backpressure: result must hold while m_ready is low.
        begin
            int base;
            base = n_starts;
            push_word(32'h01234567, 1'b0, 1'b0, 1'b0, 64'd0);
            push_word(32'h89abcdef, 1'b0, 1'b0, 1'b0, 64'd0);
            wait_mvalid("bp");
            for (int c = 0; c < 10; c++) begin
                @(negedge clk);
                check("bp_hold", {m_valid, s_ready, 30'd0, 32'(n_starts - base)}, {1'b1, 1'b0, 30'd0, 32'd1});
                check("bp_data", m_data, CT);
            end
            accept();
        end

        // Dead core: timeout sets err exactly TIMEOUT cycles after the start pulse.
        core_dead = 1'b1;
        push_word(32'h01234567, 1'b0, 1'b1, 1'b0, 64'd0);
        push_word(32'h89abcdef, 1'b0, 1'b1, 1'b0, 64'd0);
        wait_start("to");
        for (int n = 1; n <= TIMEOUT; n++) begin
            @(negedge clk);
            if (n == TIMEOUT - 1) check("to_before", {62'd0, err, busy}, 64'b01);
            if (n == TIMEOUT)     check("to_fired", {61'd0, err, busy, s_ready}, 64'b101);
        end
        check("to_no_mvalid", 64'(m_valid), 64'd0);
        @(negedge clk);
        iv_load = 1'b1; iv = 64'd0;
        @(posedge clk);
        #1;
        iv_load = 1'b0;
        @(negedge clk);
        check("iv_clears_err", 64'(err), 64'd0);

        // Reset while waiting on the core.
        push_word(32'h11111111, 1'b1, 1'b0, 1'b0, 64'd0);
        push_word(32'h22222222, 1'b1, 1'b0, 1'b0, 64'd0);
        wait_start("mrst");
        @(negedge clk);
        check("mrst_busy", {62'd0, busy, core_mode}, 64'b11);
        rst_n = 1'b0;
        @(negedge clk);
        check("mrst_flags", {57'd0, s_ready, m_valid, core_start, core_mode, busy, err, 1'b0}, 64'd0);
        check("mrst_m_data", m_data, 64'd0);
        check("mrst_core_din", core_din, 64'd0);
        rst_n = 1'b1;
        core_dead = 1'b0;
        @(negedge clk);
        check("mrst_s_ready", 64'(s_ready), 64'd1);

        // Chain must be zero after reset, so CBC without iv_load behaves like iv=0.
        run_vec('{"cbc_after_rst", 1'b0, 1'b1, 1'b0, 64'd0, 32'h01234567, 32'h89abcdef, PT, CT});

        check("din_stable", 64'(din_bad), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
